// File: rtl/apple1_dl_pkg.sv
// rtl/apple1_dl_pkg.sv - shared command codes, state encoding and defaults for the RAM download sequencer
package apple1_dl_pkg;

  localparam int DL_ADDR_W = 15;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_HI,
    ST_A_LO,
    ST_LEN,
    ST_HOLD,
    ST_W_DATA,
    ST_W_SETUP,
    ST_W_PULSE,
    ST_R_SETUP,
    ST_R_PULSE,
    ST_R_SEND,
    ST_DONE
  } dl_state_e;

endpackage

// File: rtl/apple1_dl_pulse_gen.sv
// rtl/apple1_dl_pulse_gen.sv - emu_clk high pulse of PULSE_CYC clk cycles per access
module apple1_dl_pulse_gen #(
  parameter int PULSE_CYC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic emu_clk,
  output logic pulse_done
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);

  logic [3:0] cnt;

  // pulse_done marks the last high cycle so the caller can move on as emu_clk falls
  assign pulse_done = emu_clk && (cnt == PULSE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      emu_clk <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      emu_clk <= 1'b1;
      cnt     <= '0;
    end else if (emu_clk) begin
      if (pulse_done) emu_clk <= 1'b0;
      else            cnt     <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/apple1_ram_dl_ctrl.sv
// rtl/apple1_ram_dl_ctrl.sv - byte-stream block read/write sequencer for the Apple-1 RAM emulation port
// Optional CHECKSUM_EN: write blocks end with a modulo-256 payload sum byte on out_data.
module apple1_ram_dl_ctrl
  import apple1_dl_pkg::*;
#(
  parameter int ADDR_W    = DL_ADDR_W,
  parameter int HOLD_CYC  = 4,
  parameter int PULSE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              cpu_rdy,
  output logic              busy,
  output logic [7:0]        err_cnt,
  output logic              emu_en,
  output logic              emu_clk,
  output logic              emu_we,
  output logic [ADDR_W-1:0] emu_addr,
  output logic [7:0]        emu_di,
  input  logic [7:0]        emu_do
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  dl_state_e  state, state_next;
  logic       is_write;
  logic [8:0] count;
  logic [7:0] hold_cnt;
  logic       pulse_done;
  logic       in_fire;
`ifdef CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign in_fire = in_valid && in_ready;

  apple1_dl_pulse_gen #(.PULSE_CYC(PULSE_CYC)) u_pulse (
    .clk        (clk),
    .reset      (reset),
    .start      ((state == ST_W_SETUP) || (state == ST_R_SETUP)),
    .emu_clk    (emu_clk),
    .pulse_done (pulse_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && ((in_data == CMD_WRITE) || (in_data == CMD_READ)))
          state_next = ST_A_HI;
      end
      ST_A_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_A_LO;
      end
      ST_A_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_LEN;
      end
      ST_LEN: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_HOLD;
      end
      ST_HOLD:
        if (hold_cnt == HOLD_LAST) state_next = is_write ? ST_W_DATA : ST_R_SETUP;
      ST_W_DATA: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_W_SETUP;
      end
      ST_W_SETUP: state_next = ST_W_PULSE;
      ST_W_PULSE:
        if (pulse_done) state_next = (count == 9'd1) ? ST_DONE : ST_W_DATA;
      ST_R_SETUP: state_next = ST_R_PULSE;
      ST_R_PULSE:
        if (pulse_done) state_next = ST_R_SEND;
      ST_R_SEND:
        if (out_ready) state_next = (count == 9'd1) ? ST_DONE : ST_R_SETUP;
      ST_DONE: begin
`ifdef CHECKSUM_EN
        if (!is_write || out_ready) state_next = ST_IDLE;
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cpu_rdy   <= 1'b1;
      err_cnt   <= '0;
      emu_en    <= 1'b0;
      emu_we    <= 1'b0;
      emu_addr  <= '0;
      emu_di    <= '0;
      is_write  <= 1'b0;
      count     <= '0;
      hold_cnt  <= '0;
`ifdef CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE:
          if (in_fire) begin
            if ((in_data == CMD_WRITE) || (in_data == CMD_READ))
              is_write <= (in_data == CMD_WRITE);
            else if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end
        // the top address bit of the high byte falls outside the RAM and is dropped
        ST_A_HI: if (in_fire) emu_addr[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
        ST_A_LO: if (in_fire) emu_addr[7:0] <= in_data;
        ST_LEN:
          if (in_fire) begin
            count    <= {(in_data == 8'h00), in_data};
            cpu_rdy  <= 1'b0;
            hold_cnt <= '0;
`ifdef CHECKSUM_EN
            sum      <= '0;
`endif
          end
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) emu_en <= 1'b1;
        end
        ST_W_DATA:
          if (in_fire) begin
            emu_di <= in_data;
            emu_we <= 1'b1;
`ifdef CHECKSUM_EN
            sum    <= sum + in_data;
`endif
          end
        ST_W_PULSE:
          if (pulse_done) begin
            emu_we   <= 1'b0;
            emu_addr <= emu_addr + ADDR_W'(1);
            count    <= count - 9'd1;
            if (count == 9'd1) begin
              emu_en <= 1'b0;
`ifdef CHECKSUM_EN
              out_valid <= 1'b1;
              out_data  <= sum;
`endif
            end
          end
        ST_R_PULSE:
          if (pulse_done) begin
            out_data  <= emu_do;
            out_valid <= 1'b1;
          end
        ST_R_SEND:
          if (out_ready) begin
            out_valid <= 1'b0;
            emu_addr  <= emu_addr + ADDR_W'(1);
            count     <= count - 9'd1;
            if (count == 9'd1) emu_en <= 1'b0;
          end
        ST_DONE:
          if (state_next == ST_IDLE) begin
            cpu_rdy   <= 1'b1;
            out_valid <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apple1_ram_dl_ctrl.sv
// tb/tb_apple1_ram_dl_ctrl.sv - directed vector bench for apple1_ram_dl_ctrl with a 32 KiB RAM model
module tb_apple1_ram_dl_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        cpu_rdy;
  logic        busy;
  logic [7:0]  err_cnt;
  logic        emu_en;
  logic        emu_clk;
  logic        emu_we;
  logic [14:0] emu_addr;
  logic [7:0]  emu_di;
  logic [7:0]  emu_do;

  always #5 clk = ~clk;

  apple1_ram_dl_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .cpu_rdy(cpu_rdy),
    .busy(busy), .err_cnt(err_cnt), .emu_en(emu_en), .emu_clk(emu_clk), .emu_we(emu_we),
    .emu_addr(emu_addr), .emu_di(emu_di), .emu_do(emu_do)
  );

`ifdef CHECKSUM_EN
  localparam logic CS = 1'b1;
`else
  localparam logic CS = 1'b0;
`endif

  logic [7:0]  mem [0:32767];
  int          pulse_cnt = 0;
  int          we_cycles = 0;
  int          stab_err  = 0;
  logic [23:0] prev_bus  = '0;
  int          errors    = 0;
  int          checks    = 0;

  always @(posedge emu_clk) begin
    pulse_cnt++;
    if (emu_we) mem[emu_addr] <= emu_di;
    emu_do <= mem[emu_addr];
  end

  always @(negedge clk) begin
    if (emu_clk && !reset) begin
      if ({emu_addr, emu_di, emu_we} !== prev_bus) stab_err++;
      if (emu_en !== 1'b1) stab_err++;
    end
    prev_bus = {emu_addr, emu_di, emu_we};
    if (emu_we) we_cycles++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // entered and left at a negedge; the posedge in between accepts the byte
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (!in_ready) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int t = 0;
    while (!out_valid && t < 500) begin @(negedge clk); t++; end
    if (!out_valid) chk("recv_timeout", 32'(t), 32'd0);
    b = out_data;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".cpu_rdy"}, cpu_rdy, 1);
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ir_e, rdy_e, busy_e, en_e, clk_e, we_e, ov_e;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ir, input logic rdy,
                              input logic bz, input logic en, input logic ck, input logic we,
                              input logic ov);
    vec_t v;
    v.iv = iv; v.id = id; v.ir_e = ir; v.rdy_e = rdy; v.busy_e = bz;
    v.en_e = en; v.clk_e = ck; v.we_e = we; v.ov_e = ov;
    return v;
  endfunction

  vec_t       tv [19];
  logic [7:0] b, first;
  int         p0, w0, bad;

  initial begin
    tv[0]  = mk(1, 8'h57, 1, 1, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 8'h02, 1, 1, 1, 0, 0, 0, 0);
    tv[2]  = mk(1, 8'h80, 1, 1, 1, 0, 0, 0, 0);
    tv[3]  = mk(1, 8'h03, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 4; i < 8; i++) tv[i] = mk(1, 8'hAA, 0, 0, 1, 0, 0, 0, 0);
    tv[8]  = mk(1, 8'hAA, 1, 0, 1, 1, 0, 0, 0);
    tv[9]  = mk(1, 8'hBB, 0, 0, 1, 1, 0, 1, 0);
    tv[10] = mk(1, 8'hBB, 0, 0, 1, 1, 1, 1, 0);
    tv[11] = mk(1, 8'hBB, 1, 0, 1, 1, 0, 0, 0);
    tv[12] = mk(1, 8'hCC, 0, 0, 1, 1, 0, 1, 0);
    tv[13] = mk(1, 8'hCC, 0, 0, 1, 1, 1, 1, 0);
    tv[14] = mk(1, 8'hCC, 1, 0, 1, 1, 0, 0, 0);
    tv[15] = mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 0);
    tv[16] = mk(0, 8'h00, 0, 0, 1, 1, 1, 1, 0);
    tv[17] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, CS);
    tv[18] = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.cpu_rdy", cpu_rdy, 1);
    chk("rst.busy", busy, 0);
    chk("rst.err_cnt", err_cnt, 0);
    chk("rst.emu_en", emu_en, 0);
    chk("rst.emu_clk", emu_clk, 0);
    chk("rst.emu_we", emu_we, 0);
    chk("rst.emu_addr", emu_addr, 0);
    chk("rst.emu_di", emu_di, 0);
    reset = 1'b0;

    // cycle-exact write of AA BB CC to 0x0280
    p0 = pulse_cnt;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk($sformatf("tv%0d.in_ready", i), in_ready, tv[i].ir_e);
      chk($sformatf("tv%0d.cpu_rdy", i), cpu_rdy, tv[i].rdy_e);
      chk($sformatf("tv%0d.busy", i), busy, tv[i].busy_e);
      chk($sformatf("tv%0d.emu_en", i), emu_en, tv[i].en_e);
      chk($sformatf("tv%0d.emu_clk", i), emu_clk, tv[i].clk_e);
      chk($sformatf("tv%0d.emu_we", i), emu_we, tv[i].we_e);
      chk($sformatf("tv%0d.out_valid", i), out_valid, tv[i].ov_e);
      in_valid = tv[i].iv;
      in_data  = tv[i].id;
    end
    in_valid = 1'b0;
    chk("wr.pulses", pulse_cnt - p0, 3);
    chk("wr.mem280", mem[15'h0280], 8'hAA);
    chk("wr.mem281", mem[15'h0281], 8'hBB);
    chk("wr.mem282", mem[15'h0282], 8'hCC);

    // read back
    p0 = pulse_cnt; w0 = we_cycles;
    send_byte(8'h52); send_byte(8'h02); send_byte(8'h80); send_byte(8'h03);
    recv_byte(b); chk("rd.byte0", b, 8'hAA);
    recv_byte(b); chk("rd.byte1", b, 8'hBB);
    recv_byte(b); chk("rd.byte2", b, 8'hCC);
    wait_idle("rd");
    chk("rd.pulses", pulse_cnt - p0, 3);
    chk("rd.we_cycles", we_cycles - w0, 0);

    // high-address bit ignored and wrap to 0
    send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    wait_idle("wrap");
    chk("wrap.mem7fff", mem[15'h7FFF], 8'h11);
    chk("wrap.mem0000", mem[15'h0000], 8'h22);

    // read with host stall
    out_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h7F); send_byte(8'hFF); send_byte(8'h02);
    p0 = 0;
    while (!out_valid && p0 < 500) begin @(negedge clk); p0++; end
    chk("stall.first_valid", out_valid, 1);
    first = out_data;
    chk("stall.first_data", first, 8'h11);
    p0 = pulse_cnt; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== first) bad++;
    end
    chk("stall.hold_bad", bad, 0);
    chk("stall.no_pulse", pulse_cnt - p0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    recv_byte(b); chk("stall.second", b, 8'h22);
    wait_idle("stall");

    // rejected command bytes
    send_byte(8'h00); send_byte(8'h41);
    chk("err.err_cnt", err_cnt, 2);
    chk("err.cpu_rdy", cpu_rdy, 1);
    chk("err.busy", busy, 0);

    // LEN=0 means 256 bytes
    p0 = pulse_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'hA5);
    wait_idle("len0");
    chk("len0.pulses", pulse_cnt - p0, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== (8'(i) ^ 8'hA5)) bad++;
    chk("len0.mem_bad", bad, 0);

    // reset while emu_clk is high
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01); send_byte(8'h33);
    p0 = 0;
    while (!emu_clk && p0 < 20) begin @(negedge clk); p0++; end
    chk("rstmid.in_pulse", emu_clk, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.emu_en", emu_en, 0);
    chk("rstmid.emu_clk", emu_clk, 0);
    chk("rstmid.cpu_rdy", cpu_rdy, 1);
    chk("rstmid.busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

`ifdef CHECKSUM_EN
    out_ready = 1'b0;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'hFF);
    p0 = 0;
    while (!out_valid && p0 < 500) begin @(negedge clk); p0++; end
    chk("cs.valid", out_valid, 1);
    chk("cs.data", out_data, 8'h00);
    chk("cs.waiting", busy, 1);
    out_ready = 1'b1;
    @(negedge clk);
    wait_idle("cs");
`endif

    chk("bus_stable_during_pulse", stab_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
